spi_sp_ram: RTL
===============

Name: spi_sp_ram

Overview:
Single-port RAM command endpoint that sits directly downstream of the SPI slave. It consumes the slave's 10-bit rx_data/rx_valid words and decodes the 2-bit command in din[9:8]. It executes address loads, writes and reads against an internal memory array. Read results go back to the slave on dout/tx_valid, where the slave serialises them onto MISO.

Parameters:
MEM_DEPTH, 256, number of 8-bit words in the array; must equal 2**ADDR_SIZE
ADDR_SIZE, 8, width of the address and data fields; din width is ADDR_SIZE+2

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
din  input  ADDR_SIZE+2  command word from SPI slave rx_data; [9:8] command, [7:0] payload
rx_valid  input  1  din qualifier from SPI slave; level, may stay high for many cycles
dout  output  ADDR_SIZE  read data to SPI slave tx_data
tx_valid  output  1  dout qualifier to SPI slave

Behaviour:
- Reset is rst_n: synchronous, active-low, on clock clk. Reset wins over any simultaneous command.
- Reset values: dout=0, tx_valid=0, wr_addr=0, rd_addr=0, rx_valid_d=0.
- Memory contents are not reset and survive rst_n. Must infer as block RAM.
- Command acceptance:
  - A command is accepted only on a rising edge of rx_valid: rx_valid=1 and rx_valid_d=0, where rx_valid_d is rx_valid registered.
  - rx_valid held high for N cycles yields exactly one command.
  - din is sampled in the acceptance cycle only.
- Command decode on din[9:8]:
  - 2'b00 (write address): wr_addr <= din[7:0]. No memory access.
  - 2'b01 (write data): mem[wr_addr] <= din[7:0], committed at the acceptance edge. wr_addr is unchanged unless the optional feature is enabled.
  - 2'b10 (read address): rd_addr <= din[7:0]. No memory access.
  - 2'b11 (read data): dout <= mem[rd_addr] and tx_valid <= 1 at the acceptance edge. din[7:0] is ignored (dummy byte).
- tx_valid handshake:
  - Rises 1 cycle after the read-data acceptance and stays high, with dout stable, until the next accepted command of any type. It clears on that command's acceptance edge.
  - If the next accepted command is itself a read-data command, tx_valid stays 1 and dout updates to the new read value.
  - Non-accepted cycles never change tx_valid.
- Read-after-write:
  - A read-data command issued after a write-data to the same address returns the new data. Writes complete before any later acceptance, so there is no bypass requirement.
  - A read-data command with no prior read-address command reads mem[0], since rd_addr resets to 0.
- Address arithmetic: wr_addr and rd_addr are ADDR_SIZE bits and wrap modulo MEM_DEPTH (255+1 -> 0).
- Reset mid-transaction:
  - tx_valid drops at the next edge with rst_n=0.
  - rx_valid_d clears, so a still-high rx_valid after reset release counts as a new rising edge and is accepted.
- No state machine beyond the acceptance/tx_valid control. Implementation budget is the edge detector, two address registers, the array and an output register.

Optional Feature:
Macro ADDR_AUTOINC_EN.
- Defined:
  - After each accepted write-data command, wr_addr <= wr_addr+1.
  - After each accepted read-data command, rd_addr <= rd_addr+1.
  - Both wrap 255 -> 0.
  - Address-load commands still overwrite the register directly.
- Not defined: addresses change only on 2'b00 / 2'b10 commands.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with rx_valid=1 and din=10'h3FF -> dout=0, tx_valid=0. The first cycle after release with rx_valid still high accepts a read of mem[0].
2. Write/read: send din=10'h012 (wr_addr=0x12), then 10'h1A5 (write 0xA5), then 10'h212 (rd_addr=0x12), then 10'h300. Each is a separate rx_valid pulse. -> tx_valid=1 exactly 1 cycle after the last acceptance, dout=8'hA5, held until the next command.
3. Held rx_valid: wr_addr=0x40, then din=10'h177 with rx_valid high for 12 cycles, then read 0x40 -> dout=8'h77. mem[0x41] is unchanged (no extra write).
4. tx_valid clear: after scenario 2, send 10'h000 -> tx_valid falls at that acceptance edge. Send 10'h300 again -> tx_valid=1, dout=8'hA5.
5. Back-to-back reads: rd_addr=0x05 with mem[0x05]=0x11 and mem[0x06]=0x22. Two read-data commands.
   - Without macro: both return 0x11.
   - With ADDR_AUTOINC_EN: returns 0x11 then 0x22. Also wr_addr=0xFF then two writes lands them at 0xFF and 0x00.
6. Reset persistence: write 0x5C to 0x80, pulse rst_n, set rd_addr=0x80, read -> dout=8'h5C.

Source files
------------

// File: rtl/spi_sp_ram.sv
// spi_sp_ram: single-port RAM command endpoint fed by an SPI slave.
// Decodes din[9:8] on the rising edge of rx_valid:
//   00 load write address, 01 write data, 10 load read address, 11 read data.
// Read results are presented on dout qualified by tx_valid.
// Optional feature macro: ADDR_AUTOINC_EN (post-increment wr_addr after each
// write-data command and rd_addr after each read-data command).
//
// Handshake: a command is taken only in the cycle where rx_valid is high and
// was low in the previous cycle, so a level held high yields exactly one
// command. tx_valid rises on the edge that accepts a read-data command and
// holds, with dout stable, until the edge that accepts the next command; if
// that command is another read-data, tx_valid stays high and dout updates.
module spi_sp_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE+1:0] din,
    input  logic                 rx_valid,
    output logic [ADDR_SIZE-1:0] dout,
    output logic                 tx_valid
);

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    // Storage is deliberately left out of reset so it maps onto block RAM.
    logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];

    logic                 rx_valid_q;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [ADDR_SIZE-1:0] dout_q;

    logic                 accept;
    logic                 wr_fire;
    logic                 rd_fire;
    cmd_e                 cmd;
    logic [ADDR_SIZE-1:0] payload;

    assign cmd     = cmd_e'(din[ADDR_SIZE+1:ADDR_SIZE]);
    assign payload = din[ADDR_SIZE-1:0];

    // Rising-edge detect on rx_valid; reset gates it so reset beats any command.
    assign accept  = rst_n & rx_valid & ~rx_valid_q;
    assign wr_fire = accept & (cmd == CMD_WR_DATA);
    assign rd_fire = accept & (cmd == CMD_RD_DATA);

    // Next-state for address registers and tx_valid; hold unless a command is accepted.
    always_comb begin
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        tx_valid_d = tx_valid_q;
        if (accept) begin
            tx_valid_d = 1'b0;
            case (cmd)
                CMD_WR_ADDR: wr_addr_d = payload;
                CMD_WR_DATA: begin
`ifdef ADDR_AUTOINC_EN
                    wr_addr_d = wr_addr_q + 1'b1;
`else
                    wr_addr_d = wr_addr_q;
`endif
                end
                CMD_RD_ADDR: rd_addr_d = payload;
                CMD_RD_DATA: begin
                    tx_valid_d = 1'b1;
`ifdef ADDR_AUTOINC_EN
                    rd_addr_d = rd_addr_q + 1'b1;
`else
                    rd_addr_d = rd_addr_q;
`endif
                end
                default: tx_valid_d = 1'b0;
            endcase
        end
    end

    // Control registers: edge detector, address pointers, tx_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    // Memory write port, committed on the acceptance edge.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_addr_q] <= payload;
        end
    end

    // Registered read port with synchronous reset on the output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (rd_fire) begin
            dout_q <= mem[rd_addr_q];
        end
    end

    assign dout     = dout_q;
    assign tx_valid = tx_valid_q;

endmodule
